// File: rtl/trace_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trace_cmp_pkg
// Brief   : Shared error codes, FSM encoding and event field layout for the
//           skew-tolerant commit-trace comparator.
// Revision: 1.0 - initial release
// ============================================================================
package trace_cmp_pkg;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DATA    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    // Event payload layout used by the emulation top when packing events
    localparam int PC_LSB     = 0;
    localparam int PC_W       = 32;
    localparam int ADDR_LSB   = 32;
    localparam int ADDR_W     = 24;
    localparam int WDATA_LSB  = 56;
    localparam int WDATA_W    = 32;
    localparam int WSTRB_LSB  = 88;
    localparam int WSTRB_W    = 4;
    localparam int KIND_LSB   = 92;
    localparam int KIND_W     = 4;
    localparam int EVT_PACK_W = KIND_LSB + KIND_W;

    function automatic logic [EVT_PACK_W-1:0] pack_event(
        input logic [PC_W-1:0]    pc,
        input logic [ADDR_W-1:0]  addr,
        input logic [WDATA_W-1:0] wdata,
        input logic [WSTRB_W-1:0] wstrb,
        input logic [KIND_W-1:0]  kind
    );
        return {kind, wstrb, wdata, addr, pc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module  : trace_fifo
// Brief   : Synchronous FIFO with an extra pointer bit for full/empty and a
//           combinational head read. No bypass: a push is visible next cycle.
// Revision: 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 192
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Pointers differ only in the wrap bit when the FIFO is full
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/trace_cmp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : trace_cmp_fifo
// Brief   : Buffers DUT and reference commit events, compares heads in order
//           under masks, latches the first mismatch/overflow/skew timeout.
//           Skew timer present only when TRACECMP_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module trace_cmp_fifo
    import trace_cmp_pkg::*;
#(
    parameter int EVT_W   = 96,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      dut_valid,
    input  logic [EVT_W-1:0]          dut_data,
    input  logic [EVT_W-1:0]          dut_mask,
    input  logic                      ref_valid,
    input  logic [EVT_W-1:0]          ref_data,
    input  logic [EVT_W-1:0]          ref_mask,
    output logic                      trace_mismatch,
    output logic [1:0]                err_code,
    output logic [CNT_W-1:0]          match_count,
    output logic [EVT_W-1:0]          fail_dut,
    output logic [EVT_W-1:0]          fail_ref,
    output logic [$clog2(DEPTH):0]    dut_level,
    output logic [$clog2(DEPTH):0]    ref_level
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_err;
    logic [1:0]         w_err_nxt;
    logic [CNT_W-1:0]   r_match;
    logic [EVT_W-1:0]   r_fail_dut;
    logic [EVT_W-1:0]   r_fail_ref;

    logic               w_run;
    logic               w_dut_full, w_dut_empty, w_ref_full, w_ref_empty;
    logic [2*EVT_W-1:0] w_dut_head, w_ref_head;
    logic [EVT_W-1:0]   w_dut_hmask, w_ref_hmask;
    logic [EVT_W-1:0]   w_dut_masked, w_ref_masked;
    logic               w_pop;
    logic               w_mismatch;
    logic               w_dut_push, w_ref_push;
    logic               w_ovf;
    logic               w_timeout;

    assign w_run = (r_state == ST_RUN);

    assign w_dut_hmask  = w_dut_head[2*EVT_W-1:EVT_W];
    assign w_ref_hmask  = w_ref_head[2*EVT_W-1:EVT_W];
    assign w_dut_masked = w_dut_head[EVT_W-1:0] & w_dut_hmask;
    assign w_ref_masked = w_ref_head[EVT_W-1:0] & w_ref_hmask;

    // Every compare pops both heads, whether or not they agree
    assign w_pop      = w_run && !w_dut_empty && !w_ref_empty;
    assign w_mismatch = w_pop && ((w_dut_hmask != w_ref_hmask) ||
                                  (w_dut_masked != w_ref_masked));

    // A full side still accepts a push when its head leaves the same cycle
    assign w_dut_push = w_run && dut_valid && (!w_dut_full || w_pop);
    assign w_ref_push = w_run && ref_valid && (!w_ref_full || w_pop);
    assign w_ovf      = w_run && ((dut_valid && w_dut_full && !w_pop) ||
                                  (ref_valid && w_ref_full && !w_pop));

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (2*EVT_W)
    ) u_dut_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (w_dut_push),
        .din   ({dut_mask, dut_data}),
        .pop   (w_pop),
        .full  (w_dut_full),
        .empty (w_dut_empty),
        .level (dut_level),
        .head  (w_dut_head)
    );

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (2*EVT_W)
    ) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (w_ref_push),
        .din   ({ref_mask, ref_data}),
        .pop   (w_pop),
        .full  (w_ref_full),
        .empty (w_ref_empty),
        .level (ref_level),
        .head  (w_ref_head)
    );

`ifdef TRACECMP_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_skew_cnt;
    logic              w_one_side;

    // Exactly one side holding events implies no pop this cycle
    assign w_one_side = (w_dut_empty != w_ref_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skew_cnt <= '0;
        end else if (clear) begin
            r_skew_cnt <= '0;
        end else if (w_run) begin
            if (w_one_side) begin
                if (r_skew_cnt != c_TO_W'(TIMEOUT)) begin
                    r_skew_cnt <= r_skew_cnt + 1'b1;
                end
            end else begin
                r_skew_cnt <= '0;
            end
        end
    end

    assign w_timeout = w_run && w_one_side &&
                       (r_skew_cnt == c_TO_W'(TIMEOUT - 1));
`else
    localparam int c_unused_timeout = TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = ERR_NONE;
        if (w_mismatch) begin
            w_err_nxt = ERR_DATA;
        end else if (w_ovf) begin
            w_err_nxt = ERR_OVF;
        end else if (w_timeout) begin
            w_err_nxt = ERR_TIMEOUT;
        end
        if (clear) begin
            w_state_nxt = ST_RUN;
        end else if (w_run && (w_err_nxt != ERR_NONE)) begin
            w_state_nxt = ST_FROZEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= ERR_NONE;
            r_match    <= '0;
            r_fail_dut <= '0;
            r_fail_ref <= '0;
        end else if (clear) begin
            r_err      <= ERR_NONE;
            r_match    <= '0;
            r_fail_dut <= '0;
            r_fail_ref <= '0;
        end else begin
            if (w_run && (w_err_nxt != ERR_NONE)) begin
                r_err <= w_err_nxt;
            end
            if (w_mismatch) begin
                r_fail_dut <= w_dut_masked;
                r_fail_ref <= w_ref_masked;
            end else if (w_pop) begin
                r_match <= r_match + CNT_W'(1);
            end
        end
    end

    assign err_code       = r_err;
    assign trace_mismatch = (r_err != ERR_NONE);
    assign match_count    = r_match;
    assign fail_dut       = r_fail_dut;
    assign fail_ref       = r_fail_ref;

endmodule
`default_nettype wire

// File: tb/tb_trace_cmp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_cmp_fifo
// Brief   : Directed self-checking bench for trace_cmp_fifo with a pair
//           scoreboard drained as the comparator reports matches/mismatches.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trace_cmp_fifo;

    localparam int EVT_W   = 96;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 32;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             dut_valid;
    logic [EVT_W-1:0] dut_data;
    logic [EVT_W-1:0] dut_mask;
    logic             ref_valid;
    logic [EVT_W-1:0] ref_data;
    logic [EVT_W-1:0] ref_mask;
    logic             trace_mismatch;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] match_count;
    logic [EVT_W-1:0] fail_dut;
    logic [EVT_W-1:0] fail_ref;
    logic [LW-1:0]    dut_level;
    logic [LW-1:0]    ref_level;

    typedef struct {
        bit               is_match;
        logic [EVT_W-1:0] exp_dut;
        logic [EVT_W-1:0] exp_ref;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               n_chk = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] prev_cnt = '0;
    logic             prev_mis = 1'b0;
    logic [1:0]       exp_to;

    trace_cmp_fifo #(
        .EVT_W   (EVT_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .dut_valid      (dut_valid),
        .dut_data       (dut_data),
        .dut_mask       (dut_mask),
        .ref_valid      (ref_valid),
        .ref_data       (ref_data),
        .ref_mask       (ref_mask),
        .trace_mismatch (trace_mismatch),
        .err_code       (err_code),
        .match_count    (match_count),
        .fail_dut       (fail_dut),
        .fail_ref       (fail_ref),
        .dut_level      (dut_level),
        .ref_level      (ref_level)
    );

    always #5 clk = ~clk;

    function automatic logic [EVT_W-1:0] ev(input int i);
        logic [63:0] hi;
        hi = 64'hC0DE_0000_F00D_0000 ^ {32'(i), 32'(i)};
        return {hi, 32'h0000_1230 + 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [EVT_W-1:0] dd, input logic [EVT_W-1:0] dm,
                           input logic [EVT_W-1:0] rd, input logic [EVT_W-1:0] rm);
        exp_t e;
        e.exp_dut  = dd & dm;
        e.exp_ref  = rd & rm;
        e.is_match = (dm == rm) && (e.exp_dut == e.exp_ref);
        sb_q.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        sb_q.delete();
        tick();
        clear = 1'b0;
    endtask

    // DUT events at cycles 0-7, reference copies at cycles 3-10
    task automatic run_pairs(input logic [EVT_W-1:0] ref_flip4, input logic [EVT_W-1:0] mask4,
                             input bit exp_err, input string tag);
        for (int c = 0; c < 11; c++) begin
            dut_valid = (c < 8);
            ref_valid = (c >= 3);
            if (c < 8) begin
                dut_data = ev(c);
                dut_mask = (c == 4) ? mask4 : '1;
            end
            if (c >= 3) begin
                ref_data = ev(c - 3) ^ ((c - 3 == 4) ? ref_flip4 : '0);
                ref_mask = (c - 3 == 4) ? mask4 : '1;
                sb_push(ev(c - 3), (c - 3 == 4) ? mask4 : '1, ref_data, ref_mask);
            end
            tick();
            if (c == 2) begin
                chk({tag, "_dut_level_c2"}, dut_level, 3);
                chk({tag, "_ref_level_c2"}, ref_level, 0);
            end
            if (c == 7) chk({tag, "_mis_before"}, trace_mismatch, 0);
            if (c == 8) begin
                chk({tag, "_mis_at"}, trace_mismatch, exp_err);
                chk({tag, "_err_at"}, err_code, exp_err ? 2'd1 : 2'd0);
            end
        end
        dut_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    // Scoreboard drain: each count step or fresh data error consumes one pair
    always @(negedge clk) begin
        if (!rst && !clear) begin
            if (match_count != prev_cnt && match_count != '0) begin
                chk("sb_has_entry_match", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("sb_pair_is_match", mon_e.is_match, 1);
                    chk("sb_count_step", match_count, prev_cnt + 1);
                end
            end
            if (trace_mismatch && !prev_mis && err_code == 2'd1) begin
                chk("sb_has_entry_mis", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("sb_pair_is_mis", mon_e.is_match, 0);
                    chk("sb_fail_dut", fail_dut, mon_e.exp_dut);
                    chk("sb_fail_ref", fail_ref, mon_e.exp_ref);
                end
            end
        end
        prev_cnt = match_count;
        prev_mis = trace_mismatch;
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef TRACECMP_TIMEOUT_EN
        exp_to = 2'd2;
`else
        exp_to = 2'd0;
`endif
        rst = 1'b1; clear = 1'b0;
        dut_valid = 1'b0; ref_valid = 1'b0;
        dut_data = '0; dut_mask = '0; ref_data = '0; ref_mask = '0;
        repeat (2) tick();
        chk("rst_mismatch", trace_mismatch, 0);
        chk("rst_err", err_code, 0);
        chk("rst_count", match_count, 0);
        chk("rst_fail_dut", fail_dut, 0);
        chk("rst_fail_ref", fail_ref, 0);
        chk("rst_dut_level", dut_level, 0);
        chk("rst_ref_level", ref_level, 0);
        rst = 1'b0;
        tick();

        // Skewed identical streams
        run_pairs('0, '1, 1'b0, "t1");
        repeat (3) tick();
        chk("t1_count", match_count, 8);
        chk("t1_mis", trace_mismatch, 0);
        chk("t1_dut_level", dut_level, 0);
        chk("t1_ref_level", ref_level, 0);

        // Fifth event differs in bit 0
        do_clear();
        run_pairs(96'h1, '1, 1'b1, "t2");
        repeat (2) tick();
        chk("t2_count", match_count, 4);
        chk("t2_err", err_code, 1);
        chk("t2_fail_dut", fail_dut, ev(4));
        chk("t2_fail_ref", fail_ref, ev(4) ^ 96'h1);
        chk("t2_dut_level_held", dut_level, 3);
        chk("t2_ref_level_held", ref_level, 1);

        // Same difference masked off on both sides
        do_clear();
        chk("t3_clear_err", err_code, 0);
        run_pairs(96'h1, ~96'h1, 1'b0, "t3");
        repeat (3) tick();
        chk("t3_count", match_count, 8);
        chk("t3_err", err_code, 0);

        // Overflow on the 17th DUT push
        do_clear();
        for (int c = 0; c < 17; c++) begin
            dut_valid = 1'b1;
            dut_data  = ev(c);
            dut_mask  = '1;
            tick();
            if (c == 15) begin
                chk("t4_level_full", dut_level, 16);
                chk("t4_err_before", err_code, 0);
            end
        end
        dut_valid = 1'b0;
        chk("t4_err_ovf", err_code, 3);
        chk("t4_mis_ovf", trace_mismatch, 1);
        chk("t4_level_after", dut_level, 16);
        tick();
        chk("t4_level_held", dut_level, 16);

        // Lone DUT event: skew timeout 32 edges after head arrival
        do_clear();
        dut_valid = 1'b1;
        dut_data  = ev(20);
        dut_mask  = '1;
        tick();
        dut_valid = 1'b0;
        repeat (31) tick();
        chk("t5_err_before", err_code, 0);
        tick();
        chk("t5_err_timeout", err_code, exp_to);
        chk("t5_dut_level", dut_level, 1);

        // Latch an error, then clear coincident with a DUT push
        do_clear();
        dut_valid = 1'b1; dut_data = ev(0); dut_mask = '1;
        ref_valid = 1'b1; ref_data = ev(0) ^ 96'h2; ref_mask = '1;
        sb_push(dut_data, dut_mask, ref_data, ref_mask);
        tick();
        dut_valid = 1'b0; ref_valid = 1'b0;
        repeat (2) tick();
        chk("t6_err_latched", err_code, 1);
        clear = 1'b1;
        dut_valid = 1'b1; dut_data = ev(9);
        sb_q.delete();
        tick();
        clear = 1'b0;
        dut_valid = 1'b0;
        chk("t6_clr_mis", trace_mismatch, 0);
        chk("t6_clr_err", err_code, 0);
        chk("t6_clr_count", match_count, 0);
        chk("t6_clr_fail_dut", fail_dut, 0);
        chk("t6_clr_fail_ref", fail_ref, 0);
        chk("t6_clr_dut_level", dut_level, 0);
        chk("t6_clr_ref_level", ref_level, 0);
        dut_valid = 1'b1; dut_data = ev(1); dut_mask = '1;
        ref_valid = 1'b1; ref_data = ev(1); ref_mask = '1;
        sb_push(dut_data, dut_mask, ref_data, ref_mask);
        tick();
        dut_valid = 1'b0; ref_valid = 1'b0;
        repeat (2) tick();
        chk("t6_count", match_count, 1);
        chk("t6_err", err_code, 0);
        chk("t6_sb_drained", sb_q.size(), 0);

        // Asynchronous reset mid-operation
        dut_valid = 1'b1; dut_data = ev(2); dut_mask = '1;
        tick();
        dut_data = ev(3);
        tick();
        dut_valid = 1'b0;
        chk("t7_level_pre", dut_level, 2);
        #2 rst = 1'b1;
        #1;
        chk("t7_async_level", dut_level, 0);
        chk("t7_async_count", match_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_level_post", dut_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
